// File: rtl/unidade_controle_sinfonia.sv
// rtl/unidade_controle_sinfonia.sv - Sinfonia do Espectro control unit FSM
// Sequences intro scroll, song select, note playback, player input, scoring and game end.
module unidade_controle_sinfonia #(
  parameter int PASSOS_MSG = 18,
  parameter int MAX_ERROS  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_in,
  input  logic       fimL,
  input  logic       enderecoIgualLimite,
  input  logic       botoesIgualMemoria,
  input  logic       tem_jogada,
  input  logic       timeout,
  input  logic       muda_nota,
  input  logic       timeout_contador_msg,
  output logic       zera_registrador_botoes,
  output logic       enable_registrador_botoes,
  output logic       enable_contador_rodada,
  output logic       zera_contador_rodada,
  output logic       enable_contador_jogada,
  output logic       zera_contador_jogada,
  output logic       zera_timer_msg,
  output logic       enable_timer_msg,
  output logic       zera_contador_msg,
  output logic       enable_contador_msg,
  output logic       enable_registrador_musica,
  output logic       zeraT,
  output logic       contaT,
  output logic       zera_timeout_buzzer,
  output logic       conta_timeout_buzzer,
  output logic       mostraJ,
  output logic       mostraB,
  output logic       contaErro,
  output logic       zeraErro,
  output logic       zeraPontos,
  output logic       regPontos,
  output logic       sel_memoria_arduino,
  output logic       activateArduino,
  output logic       calcular,
  output logic       nivel,
  output logic [1:0] contagem_display,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    MENSAGEM       = 4'd1,
    ESCOLHE_MUSICA = 4'd2,
    PREPARA        = 4'd3,
    ESPERA_NOTA    = 4'd4,
    MOSTRA_NOTA    = 4'd5,
    PROXIMA_NOTA   = 4'd6,
    INICIO_JOGADA  = 4'd7,
    ESPERA_JOGADA  = 4'd8,
    REGISTRA       = 4'd9,
    COMPARA        = 4'd10,
    PROXIMA_JOGADA = 4'd11,
    ERRO           = 4'd12,
    FIM_RODADA     = 4'd13,
    PROXIMA_RODADA = 4'd14,
    FIM_JOGO       = 4'd15
  } state_t;

  localparam logic [7:0] PASSOS_W = 8'(PASSOS_MSG);
  localparam logic [7:0] MAX_W    = 8'(MAX_ERROS);

  state_t     state, next;
  logic [7:0] step;
  logic [7:0] erros;
  logic [7:0] erros_inc;

  assign erros_inc = (erros == 8'hFF) ? erros : erros + 8'd1;
  assign db_estado = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= INICIAL;
      step             <= 8'd0;
      erros            <= 8'd0;
      nivel            <= 1'b0;
      contagem_display <= 2'd0;
    end else begin
      state            <= next;
      contagem_display <= contagem_display + 2'd1;
      if (state == INICIAL && iniciar) begin
        nivel <= nivel_in;
        step  <= 8'd0;
        erros <= 8'd0;
      end
      if (state == MENSAGEM && timeout_contador_msg)
        step <= step + 8'd1;
      if (state == ERRO)
        erros <= erros_inc;
    end
  end

  always_comb begin
    next                      = state;
    zera_registrador_botoes   = 1'b0;
    enable_registrador_botoes = 1'b0;
    enable_contador_rodada    = 1'b0;
    zera_contador_rodada      = 1'b0;
    enable_contador_jogada    = 1'b0;
    zera_contador_jogada      = 1'b0;
    zera_timer_msg            = 1'b0;
    enable_timer_msg          = 1'b0;
    zera_contador_msg         = 1'b0;
    enable_contador_msg       = 1'b0;
    enable_registrador_musica = 1'b0;
    zeraT                     = 1'b0;
    contaT                    = 1'b0;
    zera_timeout_buzzer       = 1'b0;
    conta_timeout_buzzer      = 1'b0;
    mostraJ                   = 1'b0;
    mostraB                   = 1'b0;
    contaErro                 = 1'b0;
    zeraErro                  = 1'b0;
    zeraPontos                = 1'b0;
    regPontos                 = 1'b0;
    sel_memoria_arduino       = 1'b0;
    activateArduino           = 1'b0;
    calcular                  = 1'b0;
    pronto                    = 1'b0;
    case (state)
      INICIAL: begin
        if (iniciar) begin
          zera_timer_msg    = 1'b1;
          zera_contador_msg = 1'b1;
          next              = MENSAGEM;
        end
      end
      MENSAGEM: begin
        enable_timer_msg = 1'b1;
        // Leave on the same edge that makes the step count reach its target
        if (step >= PASSOS_W) begin
          next = ESCOLHE_MUSICA;
        end else if (timeout_contador_msg) begin
          enable_contador_msg = 1'b1;
          if (step + 8'd1 >= PASSOS_W) next = ESCOLHE_MUSICA;
        end
      end
      ESCOLHE_MUSICA: begin
        mostraB = 1'b1;
        if (tem_jogada) begin
          enable_registrador_musica = 1'b1;
          next                      = PREPARA;
        end
      end
      PREPARA: begin
        zera_contador_rodada    = 1'b1;
        zera_contador_jogada    = 1'b1;
        zeraErro                = 1'b1;
        zeraPontos              = 1'b1;
        zera_registrador_botoes = 1'b1;
        zera_timeout_buzzer     = 1'b1;
        zeraT                   = 1'b1;
        next                    = ESPERA_NOTA;
      end
      ESPERA_NOTA: begin
        zera_timeout_buzzer = 1'b1;
        next                = MOSTRA_NOTA;
      end
      MOSTRA_NOTA: begin
        mostraJ              = 1'b1;
        sel_memoria_arduino  = 1'b1;
        activateArduino      = 1'b1;
        conta_timeout_buzzer = 1'b1;
        if (muda_nota) next = PROXIMA_NOTA;
      end
      PROXIMA_NOTA: begin
        if (enderecoIgualLimite) begin
          next = INICIO_JOGADA;
        end else begin
          enable_contador_jogada = 1'b1;
          next                   = ESPERA_NOTA;
        end
      end
      INICIO_JOGADA: begin
        zera_contador_jogada    = 1'b1;
        zeraT                   = 1'b1;
        zera_registrador_botoes = 1'b1;
        next                    = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        contaT          = 1'b1;
        mostraB         = 1'b1;
        activateArduino = 1'b1;
        if (tem_jogada)   next = REGISTRA;
        else if (timeout) next = ERRO;
      end
      REGISTRA: begin
        enable_registrador_botoes = 1'b1;
        next                      = COMPARA;
      end
      COMPARA: begin
        if (!botoesIgualMemoria)      next = ERRO;
        else if (enderecoIgualLimite) next = FIM_RODADA;
        else                          next = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: begin
        enable_contador_jogada = 1'b1;
        zeraT                  = 1'b1;
        next                   = ESPERA_JOGADA;
      end
      ERRO: begin
        contaErro = 1'b1;
        zeraT     = 1'b1;
        next      = (erros_inc >= MAX_W) ? FIM_JOGO : ESPERA_JOGADA;
      end
      FIM_RODADA: begin
        calcular  = 1'b1;
        regPontos = 1'b1;
        next      = fimL ? FIM_JOGO : PROXIMA_RODADA;
      end
      PROXIMA_RODADA: begin
        enable_contador_rodada = 1'b1;
        zera_contador_jogada   = 1'b1;
        zeraErro               = 1'b1;
        next                   = ESPERA_NOTA;
      end
      FIM_JOGO: begin
        pronto = 1'b1;
        if (iniciar) next = INICIAL;
      end
      default: next = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_sinfonia.sv
// tb/tb_unidade_controle_sinfonia.sv - directed bench for unidade_controle_sinfonia
// Runs with PASSOS_MSG=2 and MAX_ERROS=2 to keep the scenarios short.
module tb_unidade_controle_sinfonia;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, nivel_in = 1'b0, fimL = 1'b0, enderecoIgualLimite = 1'b0;
  logic botoesIgualMemoria = 1'b0, tem_jogada = 1'b0, timeout = 1'b0;
  logic muda_nota = 1'b0, timeout_contador_msg = 1'b0;
  logic zera_registrador_botoes, enable_registrador_botoes, enable_contador_rodada;
  logic zera_contador_rodada, enable_contador_jogada, zera_contador_jogada;
  logic zera_timer_msg, enable_timer_msg, zera_contador_msg, enable_contador_msg;
  logic enable_registrador_musica, zeraT, contaT, zera_timeout_buzzer, conta_timeout_buzzer;
  logic mostraJ, mostraB, contaErro, zeraErro, zeraPontos, regPontos;
  logic sel_memoria_arduino, activateArduino, calcular, nivel, pronto;
  logic [1:0] contagem_display;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int visits, jog_pulses, msg_pulses;

  always #5 clock = ~clock;

  unidade_controle_sinfonia #(.PASSOS_MSG(2), .MAX_ERROS(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nivel_in(nivel_in), .fimL(fimL),
    .enderecoIgualLimite(enderecoIgualLimite), .botoesIgualMemoria(botoesIgualMemoria),
    .tem_jogada(tem_jogada), .timeout(timeout), .muda_nota(muda_nota),
    .timeout_contador_msg(timeout_contador_msg),
    .zera_registrador_botoes(zera_registrador_botoes),
    .enable_registrador_botoes(enable_registrador_botoes),
    .enable_contador_rodada(enable_contador_rodada), .zera_contador_rodada(zera_contador_rodada),
    .enable_contador_jogada(enable_contador_jogada), .zera_contador_jogada(zera_contador_jogada),
    .zera_timer_msg(zera_timer_msg), .enable_timer_msg(enable_timer_msg),
    .zera_contador_msg(zera_contador_msg), .enable_contador_msg(enable_contador_msg),
    .enable_registrador_musica(enable_registrador_musica), .zeraT(zeraT), .contaT(contaT),
    .zera_timeout_buzzer(zera_timeout_buzzer), .conta_timeout_buzzer(conta_timeout_buzzer),
    .mostraJ(mostraJ), .mostraB(mostraB), .contaErro(contaErro), .zeraErro(zeraErro),
    .zeraPontos(zeraPontos), .regPontos(regPontos), .sel_memoria_arduino(sel_memoria_arduino),
    .activateArduino(activateArduino), .calcular(calcular), .nivel(nivel),
    .contagem_display(contagem_display), .pronto(pronto), .db_estado(db_estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From INICIAL down to ESPERA_JOGADA through a one-note round
  task automatic go_to_play(input logic lvl);
    nivel_in = lvl; iniciar = 1'b1; tick(); iniciar = 1'b0;
    timeout_contador_msg = 1'b1; tick();
    timeout_contador_msg = 1'b0; tick();
    timeout_contador_msg = 1'b1; tick();
    timeout_contador_msg = 1'b0;
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    tick(); tick();
    muda_nota = 1'b1; tick(); muda_nota = 1'b0;
    enderecoIgualLimite = 1'b1; tick(); enderecoIgualLimite = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_estado", 32'(db_estado), 0);
    check("rst_disp", 32'(contagem_display), 0);
    check("rst_pronto", 32'(pronto), 0);
    check("rst_nivel", 32'(nivel), 0);
    reset = 1'b0;
    tick();
    check("disp_inc", 32'(contagem_display), 1);
    check("idle_stay", 32'(db_estado), 0);

    // Game 1: intro scroll
    nivel_in = 1'b1; iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("mensagem", 32'(db_estado), 1);
    check("nivel_latch", 32'(nivel), 1);
    check("timer_en", 32'(enable_timer_msg), 1);
    msg_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      timeout_contador_msg = (i % 2 == 0);
      #1;
      if (db_estado == 4'd1) msg_pulses += int'(enable_contador_msg);
      tick();
    end
    timeout_contador_msg = 1'b0;
    check("msg_pulses", 32'(msg_pulses), 2);
    check("escolhe", 32'(db_estado), 2);
    check("escolhe_mostraB", 32'(mostraB), 1);

    tem_jogada = 1'b1; #1;
    check("musica_mealy", 32'(enable_registrador_musica), 1);
    tick(); tem_jogada = 1'b0;
    check("prepara", 32'(db_estado), 3);
    check("prepara_zeraErro", 32'(zeraErro), 1);
    tick();
    check("espera_nota_buz", 32'(zera_timeout_buzzer), 1);

    // Three-note round
    visits = 0; jog_pulses = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (db_estado == 4'd5 && mostraJ) visits++;
      tick();
      muda_nota = 1'b1; tick(); muda_nota = 1'b0;
      enderecoIgualLimite = (n == 2); #1;
      jog_pulses += int'(enable_contador_jogada);
      tick();
    end
    enderecoIgualLimite = 1'b0;
    check("note_visits", 32'(visits), 3);
    check("note_jog_pulses", 32'(jog_pulses), 2);
    check("inicio_jogada", 32'(db_estado), 7);
    check("inicio_zeraT", 32'(zeraT), 1);
    tick();
    check("espera_jogada", 32'(db_estado), 8);
    check("espera_contaT", 32'(contaT), 1);

    // Wrong note
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    check("registra_en", 32'(enable_registrador_botoes), 1);
    botoesIgualMemoria = 1'b0; tick(); tick();
    check("erro_state", 32'(db_estado), 12);
    check("erro_contaErro", 32'(contaErro), 1);
    check("erro_no_jog", 32'(enable_contador_jogada), 0);
    tick();
    check("erro_retry", 32'(db_estado), 8);

    // tem_jogada wins over timeout
    tem_jogada = 1'b1; timeout = 1'b1; tick(); tem_jogada = 1'b0; timeout = 1'b0;
    check("both_registra", 32'(db_estado), 9);
    check("both_no_erro", 32'(contaErro), 0);
    botoesIgualMemoria = 1'b1; tick(); tick();
    check("prox_jogada_en", 32'(enable_contador_jogada), 1);
    tick();
    check("back_to_8", 32'(db_estado), 8);

    // Correct final note, fimL=0 -> next round
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    enderecoIgualLimite = 1'b1; tick(); tick();
    check("fim_rodada", 32'(db_estado), 13);
    fimL = 1'b0; tick();
    check("prox_rodada_en", 32'(enable_contador_rodada), 1);
    tick(); tick();
    muda_nota = 1'b1; tick(); muda_nota = 1'b0;
    tick(); tick();
    check("round2_espera", 32'(db_estado), 8);

    // Correct final note, fimL=1 -> game over
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    tick(); tick();
    check("calcular_on", 32'(calcular), 1);
    check("regPontos_on", 32'(regPontos), 1);
    fimL = 1'b1; tick(); fimL = 1'b0; enderecoIgualLimite = 1'b0;
    check("fim_jogo", 32'(db_estado), 15);
    check("calcular_off", 32'(calcular), 0);
    check("pronto_on", 32'(pronto), 1);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("restart_inicial", 32'(db_estado), 0);

    // Game 2: asynchronous reset in ESPERA_JOGADA
    go_to_play(1'b1);
    check("g2_espera", 32'(db_estado), 8);
    #2; reset = 1'b1; #1;
    check("async_estado", 32'(db_estado), 0);
    check("async_disp", 32'(contagem_display), 0);
    check("async_contaT", 32'(contaT), 0);
    check("async_nivel", 32'(nivel), 0);
    tick(); reset = 1'b0;

    // Game 3: two timeouts reach MAX_ERROS
    go_to_play(1'b0);
    check("g3_espera", 32'(db_estado), 8);
    check("g3_nivel", 32'(nivel), 0);
    timeout = 1'b1; tick(); timeout = 1'b0;
    check("to1_erro", 32'(contaErro), 1);
    tick();
    check("to1_retry", 32'(db_estado), 8);
    timeout = 1'b1; tick(); timeout = 1'b0;
    check("to2_erro", 32'(db_estado), 12);
    tick();
    check("to2_fim", 32'(db_estado), 15);
    check("to2_pronto", 32'(pronto), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
